// File: rtl/vec_store_if.sv
// Bus between a vector-store issuer and vec_store_sequencer. The issuer holds
// the request side and the sequencer drives the memory write port back to it.
interface vec_store_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  // start is a request, not a valid/ready pair. It is taken only on a posedge
  // where the sequencer is idle and abort is low; at any other time it is
  // dropped, never held over. busy high means a request would be ignored.
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, base_addr, data_in,
    input  mem_addr, mem_wdata, mem_we, busy, done
  );

  modport slave (
    input  start, abort, base_addr, data_in,
    output mem_addr, mem_wdata, mem_we, busy, done
  );
endinterface

// File: rtl/vec_store_sequencer.sv
// Writes one burst of LANES serialized words to data memory, highest lane first,
// at base + lane*STRIDE. Memory outputs are registered; done pulses after the burst.
module vec_store_sequencer #(
  parameter int LANES  = 16,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int STRIDE = 1
) (
  input  logic       clk,
  input  logic       rst,
  vec_store_if.slave bus,
  output logic [1:0] dbg_state
);

  localparam int                IDX_W    = $clog2(LANES) + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LANES - 1);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              done_q;
  logic              accept;
  logic              beat;
  logic [ADDR_W-1:0] lane_addr;

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    beat      = 1'b0;
    lane_addr = base_q + ADDR_W'(idx_q) * STRIDE_A;
    case (state_q)
      ST_IDLE: begin
        // abort wins over a coincident start
        if (bus.start && !bus.abort) begin
          accept  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = bus.abort ? ST_IDLE : ST_WRITE;
      end
      ST_WRITE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          beat = 1'b1;
          if (idx_q == IDX_W'(0)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= LAST_IDX;
      base_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= beat;
      done_q  <= (state_q == ST_DONE);
      if (accept) begin
        base_q <= bus.base_addr;
      end
      if (beat) begin
        addr_q  <= lane_addr;
        wdata_q <= bus.data_in;
      end
      // idx wraps back to LAST_IDX after lane 0 so it never holds an underflow value
      if (beat && idx_q != IDX_W'(0)) begin
        idx_q <= idx_q - IDX_W'(1);
      end else begin
        idx_q <= LAST_IDX;
      end
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = we_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q == ST_LOAD) || (state_q == ST_WRITE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_vec_store_sequencer.sv
// Directed bench for vec_store_sequencer: a STRIDE=1 and a STRIDE=4 instance
// run the same stimulus; each step checks outputs 1ns after the posedge.
module tb_vec_store_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [1:0] dbg0;
  logic [1:0] dbg1;

  vec_store_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();
  vec_store_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();

  assign bus1.start     = bus0.start;
  assign bus1.abort     = bus0.abort;
  assign bus1.base_addr = bus0.base_addr;
  assign bus1.data_in   = bus0.data_in;

  vec_store_sequencer #(.LANES(16), .DATA_W(16), .ADDR_W(16), .STRIDE(1)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus0.slave),
    .dbg_state (dbg0)
  );

  vec_store_sequencer #(.LANES(16), .DATA_W(16), .ADDR_W(16), .STRIDE(4)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus1.slave),
    .dbg_state (dbg1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_we"},    32'(bus0.mem_we), 0);
    chk({tag, "_busy"},  32'(bus0.busy),   0);
    chk({tag, "_done"},  32'(bus0.done),   0);
    chk({tag, "_state"}, 32'(dbg0),        0);
    chk({tag, "_we1"},   32'(bus1.mem_we), 0);
  endtask

  // n_beats < 16 aborts after that many writes; stray pulses start mid-burst and in DONE
  task automatic do_burst(input logic [15:0] base, input int n_beats, input bit stray);
    logic [15:0] lane;
    logic [15:0] exp_a0;
    logic [15:0] exp_a1;
    bus0.start     = 1'b1;
    bus0.abort     = 1'b0;
    bus0.base_addr = base;
    bus0.data_in   = 16'h5555;
    step();
    chk("load_state", 32'(dbg0),        1);
    chk("load_busy",  32'(bus0.busy),   1);
    chk("load_we",    32'(bus0.mem_we), 0);
    bus0.start     = 1'b0;
    bus0.base_addr = 16'h7777;
    bus0.data_in   = 16'hDEAD;
    step();
    chk("align_state", 32'(dbg0),        2);
    chk("align_we",    32'(bus0.mem_we), 0);
    for (int b = 0; b < n_beats; b++) begin
      lane         = 16'(15 - b);
      exp_a0       = base + lane;
      exp_a1       = base + (lane << 2);
      bus0.data_in = 16'hA000 | lane;
      bus0.start   = stray && (b == 5);
      step();
      chk("beat_we",    32'(bus0.mem_we),    1);
      chk("beat_addr",  32'(bus0.mem_addr),  32'(exp_a0));
      chk("beat_wdata", 32'(bus0.mem_wdata), 32'(16'hA000 | lane));
      chk("beat_done",  32'(bus0.done),      0);
      chk("beat_addr4", 32'(bus1.mem_addr),  32'(exp_a1));
      chk("beat_we4",   32'(bus1.mem_we),    1);
    end
    bus0.start   = 1'b0;
    bus0.data_in = 16'hBEEF;
    if (n_beats < 16) begin
      bus0.abort = 1'b1;
      step();
      bus0.abort = 1'b0;
      chk_idle_outputs("abort");
      step();
      chk_idle_outputs("post_abort");
    end else begin
      chk("last_state", 32'(dbg0),      3);
      chk("last_busy",  32'(bus0.busy), 0);
      chk("last_done",  32'(bus0.done), 0);
      bus0.start = stray;
      step();
      bus0.start = 1'b0;
      chk("done_pulse", 32'(bus0.done),   1);
      chk("done_we",    32'(bus0.mem_we), 0);
      chk("done_state", 32'(dbg0),        0);
      chk("done_pulse4", 32'(bus1.done),  1);
      step();
      chk_idle_outputs("after_done");
    end
  endtask

  initial begin
    bus0.start     = 1'b0;
    bus0.abort     = 1'b0;
    bus0.base_addr = 16'h0000;
    bus0.data_in   = 16'h0000;
    #12;
    chk_idle_outputs("reset");
    chk("reset_addr",  32'(bus0.mem_addr),  0);
    chk("reset_wdata", 32'(bus0.mem_wdata), 0);
    @(negedge clk);
    rst = 1'b0;

    // basic burst, accepted on the first posedge after reset release
    do_burst(16'h0100, 16, 1'b0);

    // abort with start in IDLE: start ignored
    bus0.start = 1'b1;
    bus0.abort = 1'b1;
    step();
    chk_idle_outputs("abort_start_idle");
    bus0.start = 1'b0;
    step();
    bus0.abort = 1'b0;
    chk_idle_outputs("abort_idle");

    // address wrap
    do_burst(16'hFFF8, 16, 1'b0);
    // stray starts ignored; STRIDE=4 instance covers 0x023C..0x0200
    do_burst(16'h0200, 16, 1'b1);
    // abort after six writes, then a full burst
    do_burst(16'h0300, 6, 1'b0);
    do_burst(16'h0400, 16, 1'b0);

    // asynchronous reset in the middle of a write burst
    bus0.start     = 1'b1;
    bus0.base_addr = 16'h0500;
    step();
    bus0.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus0.data_in = 16'h1230 + 16'(i);
      step();
    end
    chk("pre_rst_we", 32'(bus0.mem_we), 1);
    #3;
    rst = 1'b1;
    #1;
    chk_idle_outputs("async_rst");
    chk("async_rst_addr",  32'(bus0.mem_addr),  0);
    chk("async_rst_wdata", 32'(bus0.mem_wdata), 0);
    @(negedge clk);
    rst = 1'b0;
    do_burst(16'h0600, 16, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
